// File: rtl/ping_pong_sequencer.sv
// Tick, flip and load sequencing for the ping-pong counter datapath, all on clk.
// Optional build macro PP_SEQ_FLIP_PARITY_EN: pending flip toggles instead of sticking.
module ping_pong_sequencer #(
  parameter int TICK_DIV = 25000000,
  parameter int DIV_W    = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       flip_pulse,
  input  logic [3:0] max_in,
  input  logic [3:0] min_in,
  output logic       cnt_tick,
  output logic       cnt_flip,
  output logic       cnt_load,
  output logic [3:0] cfg_max,
  output logic [3:0] cfg_min,
  output logic       cfg_valid,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             pending_q, pending_d;
  logic [3:0]       cfg_max_q, cfg_max_d;
  logic [3:0]       cfg_min_q, cfg_min_d;
  logic             cnt_tick_q, cnt_tick_d;
  logic             cnt_flip_q, cnt_flip_d;
  logic             cnt_load_q, cnt_load_d;

  logic cfg_ok;
  logic at_tick;
  logic pending_upd;

  assign cfg_ok  = (max_in > min_in);
  assign at_tick = (presc_q == TICK_LAST);

  // Pending flip with this cycle's pulse folded in; also what a tick reports.
`ifdef PP_SEQ_FLIP_PARITY_EN
  assign pending_upd = pending_q ^ flip_pulse;
`else
  assign pending_upd = pending_q | flip_pulse;
`endif

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    pending_d  = pending_q;
    cfg_max_d  = cfg_max_q;
    cfg_min_d  = cfg_min_q;
    cnt_tick_d = 1'b0;
    cnt_flip_d = 1'b0;
    cnt_load_d = 1'b0;

    case (state_q)
      IDLE: begin
        presc_d   = '0;
        pending_d = 1'b0;
        if (enable) state_d = LOAD;
      end

      LOAD: begin
        presc_d   = '0;
        pending_d = 1'b0;
        if (!enable) begin
          state_d = IDLE;
        end else if (cfg_ok) begin
          state_d    = RUN;
          cfg_max_d  = max_in;
          cfg_min_d  = min_in;
          cnt_load_d = 1'b1;
        end
      end

      RUN: begin
        if (at_tick) begin
          presc_d   = '0;
          pending_d = 1'b0;
          if (cfg_ok) begin
            cfg_max_d  = max_in;
            cfg_min_d  = min_in;
            cnt_tick_d = 1'b1;
            cnt_flip_d = pending_upd;
            state_d    = enable ? RUN : PAUSE;
          end else begin
            state_d = LOAD;
          end
        end else begin
          // The RUN cycle itself still counts; freezing starts in PAUSE.
          presc_d   = presc_q + DIV_W'(1);
          pending_d = pending_upd;
          if (!enable) state_d = PAUSE;
        end
      end

      PAUSE: begin
        pending_d = pending_upd;
        if (enable) state_d = RUN;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      pending_q  <= 1'b0;
      cfg_max_q  <= 4'd0;
      cfg_min_q  <= 4'd0;
      cnt_tick_q <= 1'b0;
      cnt_flip_q <= 1'b0;
      cnt_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      pending_q  <= pending_d;
      cfg_max_q  <= cfg_max_d;
      cfg_min_q  <= cfg_min_d;
      cnt_tick_q <= cnt_tick_d;
      cnt_flip_q <= cnt_flip_d;
      cnt_load_q <= cnt_load_d;
    end
  end

  assign cnt_tick  = cnt_tick_q;
  assign cnt_flip  = cnt_flip_q;
  assign cnt_load  = cnt_load_q;
  assign cfg_max   = cfg_max_q;
  assign cfg_min   = cfg_min_q;
  assign cfg_valid = (state_q == RUN) || (state_q == PAUSE);
  assign state     = state_q;

endmodule

// File: tb/tb_ping_pong_sequencer.sv
// Scoreboard bench for ping_pong_sequencer with TICK_DIV=4: expected load/tick
// events are queued as stimulus is driven and matched as the DUT emits them.
module tb_ping_pong_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       flip_pulse;
  logic [3:0] max_in;
  logic [3:0] min_in;
  logic       cnt_tick;
  logic       cnt_flip;
  logic       cnt_load;
  logic [3:0] cfg_max;
  logic [3:0] cfg_min;
  logic       cfg_valid;
  logic [1:0] state;

  ping_pong_sequencer #(.TICK_DIV(4), .DIV_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .flip_pulse (flip_pulse),
    .max_in     (max_in),
    .min_in     (min_in),
    .cnt_tick   (cnt_tick),
    .cnt_flip   (cnt_flip),
    .cnt_load   (cnt_load),
    .cfg_max    (cfg_max),
    .cfg_min    (cfg_min),
    .cfg_valid  (cfg_valid),
    .state      (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] K_LOAD = 2'b10;
  localparam logic [1:0] K_TICK = 2'b01;

`ifdef PP_SEQ_FLIP_PARITY_EN
  localparam logic TWO_FLIP = 1'b0;
`else
  localparam logic TWO_FLIP = 1'b1;
`endif

  typedef struct {
    logic [1:0] kind;
    int         at;
    logic       flip;
    logic [3:0] mx;
    logic [3:0] mn;
  } evt_t;

  evt_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push(input logic [1:0] kind, input int at, input logic flip,
                      input logic [3:0] mx, input logic [3:0] mn);
    evt_t e;
    e.kind = kind;
    e.at   = at;
    e.flip = flip;
    e.mx   = mx;
    e.mn   = mn;
    exp_q.push_back(e);
  endtask

  // Return #1 after the edge that starts cycle c.
  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    evt_t e;
    if (cnt_tick || cnt_load) begin
      if (exp_q.size() == 0) begin
        check("evt_unexpected_q_size", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("evt_kind", {cnt_load, cnt_tick}, e.kind);
        check("evt_cycle", cyc, e.at);
        check("evt_flip", cnt_flip, e.flip);
        check("evt_cfg_max", cfg_max, e.mx);
        check("evt_cfg_min", cfg_min, e.mn);
      end
    end
    if (cnt_flip) check("flip_needs_tick", cnt_tick, 1);
  end

  int l0, t1, t2, l2, t3, l3;

  initial begin
    rst_n = 1'b0; enable = 1'b0; flip_pulse = 1'b0; max_in = 4'd0; min_in = 4'd0;

    wait_to(3);
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_outs", {cnt_tick, cnt_flip, cnt_load, cfg_valid, cfg_max, cfg_min}, 0);

    // Bring-up: IDLE -> LOAD -> RUN with 9/2.
    wait_to(4);
    rst_n = 1'b1; enable = 1'b1; max_in = 4'd9; min_in = 4'd2;
    l0 = 6;
    push(K_LOAD, l0, 1'b0, 4'd9, 4'd2);
    wait_to(5);
    @(negedge clk);
    check("load_state", state, 1);
    check("load_valid", cfg_valid, 0);

    // Flip one cycle after load, then a flip on the tick edge.
    wait_to(l0 + 1); flip_pulse = 1'b1;
    push(K_TICK, l0 + 4, 1'b1, 4'd9, 4'd2);
    wait_to(l0 + 2); flip_pulse = 1'b0;
    wait_to(l0 + 7); flip_pulse = 1'b1;
    push(K_TICK, l0 + 8, 1'b1, 4'd9, 4'd2);
    push(K_TICK, l0 + 12, 1'b0, 4'd9, 4'd2);
    wait_to(l0 + 8); flip_pulse = 1'b0;

    // Two flips between ticks.
    wait_to(l0 + 12); flip_pulse = 1'b1;
    wait_to(l0 + 13); flip_pulse = 1'b0;
    wait_to(l0 + 14); flip_pulse = 1'b1;
    push(K_TICK, l0 + 16, TWO_FLIP, 4'd9, 4'd2);
    wait_to(l0 + 15); flip_pulse = 1'b0;

    // A bound change mid-interval only lands on the next tick.
    wait_to(l0 + 17); max_in = 4'd12;
    push(K_TICK, l0 + 20, 1'b0, 4'd12, 4'd2);
    wait_to(l0 + 18);
    @(negedge clk);
    check("cfg_hold_max", cfg_max, 9);
    t1 = l0 + 20;

    // Five-cycle pause starting after cycle 2 of an interval, with a flip inside it.
    wait_to(t1 + 2); enable = 1'b0;
    wait_to(t1 + 4); flip_pulse = 1'b1;
    @(negedge clk);
    check("pause_state", state, 3);
    check("pause_valid", cfg_valid, 1);
    wait_to(t1 + 5); flip_pulse = 1'b0;
    push(K_TICK, t1 + 9, 1'b1, 4'd12, 4'd2);
    wait_to(t1 + 7); enable = 1'b1;
    push(K_TICK, t1 + 13, 1'b0, 4'd12, 4'd2);
    t2 = t1 + 13;

    // Equal bounds: boundary falls back to LOAD, pending flip dropped.
    wait_to(t2 + 1); max_in = 4'd3; min_in = 4'd3;
    wait_to(t2 + 2); flip_pulse = 1'b1;
    wait_to(t2 + 3); flip_pulse = 1'b0;
    wait_to(t2 + 4); min_in = 4'd1;
    @(negedge clk);
    check("inv_state", state, 1);
    check("inv_valid", cfg_valid, 0);
    check("inv_no_tick", cnt_tick, 0);
    l2 = t2 + 5;
    push(K_LOAD, l2, 1'b0, 4'd3, 4'd1);

    // enable drop coinciding with the tick edge: tick still issues, then PAUSE.
    push(K_TICK, l2 + 4, 1'b0, 4'd3, 4'd1);
    wait_to(l2 + 3); enable = 1'b0;
    wait_to(l2 + 4); enable = 1'b1;
    @(negedge clk);
    check("coincide_state", state, 3);
    push(K_TICK, l2 + 9, 1'b0, 4'd3, 4'd1);
    t3 = l2 + 9;

    // Reset mid-RUN with a flip pending.
    wait_to(t3 + 1); flip_pulse = 1'b1;
    wait_to(t3 + 2); flip_pulse = 1'b0; rst_n = 1'b0;
    wait_to(t3 + 3); rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_state", state, 0);
    check("mid_rst_outs", {cnt_tick, cnt_flip, cnt_load, cfg_valid, cfg_max, cfg_min}, 0);
    l3 = t3 + 5;
    push(K_LOAD, l3, 1'b0, 4'd3, 4'd1);
    push(K_TICK, l3 + 4, 1'b0, 4'd3, 4'd1);
    wait_to(l3 + 5); flip_pulse = 1'b1;
    push(K_TICK, l3 + 8, 1'b1, 4'd3, 4'd1);
    wait_to(l3 + 6); flip_pulse = 1'b0;
    wait_to(l3 + 9); enable = 1'b0;

    wait_to(l3 + 14);
    @(negedge clk);
    check("evt_left", exp_q.size(), 0);
    check("end_state", state, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
